traffic_cmd_ctrl: RTL and testbench

- Operator command front-end that sits directly upstream of each traffic light instance.
- Converts raw board buttons and switches into clean, single-cycle `inst_send` / `inst_go` commands with registered configuration fields.
- Enforces a configure-while-stopped policy, flags bad commands, and reports which lights have a complete red/green configuration.
- One instance drives all lights; lights share its outputs and filter on `traffic_sel`.

---
 rtl/traffic_pkg.sv | 37 +++
 rtl/btn_debounce.sv | 66 ++++++
 rtl/traffic_cmd_ctrl.sv | 167 ++++++++++++++++
 tb/tb_traffic_cmd_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic light command front-end.
//   - state_t      : command FSM states (IDLE = 0, RUN = 1)
//   - COLOR_*      : encoding of the colour select switch
//   - TIME_W/SEL_W : widths of the time and light-select fields
//   - DEFAULT_TIME : nominal phase time used by the light instances
//   - cmd_fields_t : the four configuration fields forwarded to the lights
//   - time_valid() : a requested time of zero is not a legal phase length
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic COLOR_RED   = 1'b0;
    localparam logic COLOR_GREEN = 1'b1;

    localparam int TIME_W = 4;
    localparam int SEL_W  = 2;

    localparam logic [TIME_W-1:0] DEFAULT_TIME = 4'd10;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic              color;
        logic              start;
        logic [TIME_W-1:0] secs;
    } cmd_fields_t;

    function automatic logic time_valid(input logic [TIME_W-1:0] t);
        return t != '0;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw asynchronous button and accepts a new level only after
// DEBOUNCE_CYCLES+1 consecutive synchronised samples that disagree with the
// current debounced level. A rising edge of the debounced level produces a
// single-cycle pulse; falling edges produce nothing.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-low
//   raw        in   raw button input (asynchronous)
//   level      out  debounced button level
//   rise_pulse out  one-cycle pulse on a debounced rising edge
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync_a;
    logic             sync_b;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the synchronizer chain
    // depends on this to stay two stages deep).
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the synchronizer flops are reset too, so a button held
            // through reset has to re-qualify from scratch.
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_a  <= raw;
            sync_b  <= sync_a;
            level_d <= level;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LIMIT) begin
                // Counter has seen DEBOUNCE_CYCLES disagreeing samples and
                // this is one more: accept the new level.
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Both operands are flop outputs, so the pulse is glitch-free and lasts
    // exactly the one cycle between level rising and level_d following it.
    assign rise_pulse = level & ~level_d;

endmodule

// File: rtl/traffic_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_cmd_ctrl
// Operator command front-end shared by all traffic light instances. Turns the
// send/go buttons into clean one-cycle strobes, registers the configuration
// fields on every accepted send, enforces configure-while-stopped, keeps a
// sticky error flag for rejected sends and tracks which lights have both a
// red and a green time.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-low
//   btn_send     in   raw "send configuration" button
//   btn_go       in   raw "start/stop" button
//   sw_sel       in   light number to configure
//   sw_color     in   1 = green time, 0 = red time
//   sw_start     in   start colour for the addressed light
//   sw_time      in   requested time in seconds (1..15)
//   inst_send    out  one-cycle configuration strobe
//   inst_go      out  one-cycle run-toggle strobe
//   traffic_sel  out  registered light number
//   color_sel    out  registered colour select
//   start_color  out  registered start colour
//   input_time   out  registered time
//   running      out  1 while the lights run
//   cfg_err      out  sticky bad-command flag, cleared by an accepted send
//   cfg_mask     out  bit n set once light n has both red and green times
// -----------------------------------------------------------------------------
module traffic_cmd_ctrl
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int NUM_LIGHTS      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_send,
    input  logic                  btn_go,
    input  logic [SEL_W-1:0]      sw_sel,
    input  logic                  sw_color,
    input  logic                  sw_start,
    input  logic [TIME_W-1:0]     sw_time,
    output logic                  inst_send,
    output logic                  inst_go,
    output logic [SEL_W-1:0]      traffic_sel,
    output logic                  color_sel,
    output logic                  start_color,
    output logic [TIME_W-1:0]     input_time,
    output logic                  running,
    output logic                  cfg_err,
    output logic [NUM_LIGHTS-1:0] cfg_mask
);

    logic send_level, send_rise;
    logic go_level,   go_rise;
    logic p_send,     p_go;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_send_db (
        .clk        (clk),
        .rst        (rst),
        .raw        (btn_send),
        .level      (send_level),
        .rise_pulse (send_rise)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go_db (
        .clk        (clk),
        .rst        (rst),
        .raw        (btn_go),
        .level      (go_level),
        .rise_pulse (go_rise)
    );

    // A rise pulse already implies a high level; the AND states explicitly
    // that commands only fire while the debounced button is settled high.
    assign p_send = send_rise & send_level;
    assign p_go   = go_rise   & go_level;

    state_t                state,         state_nxt;
    cmd_fields_t           fields,        fields_nxt;
    logic                  send_nxt,      go_nxt;
    logic                  err_nxt;
    logic [NUM_LIGHTS-1:0] red_written,   red_nxt;
    logic [NUM_LIGHTS-1:0] green_written, green_nxt;

    // NOTE: every signal driven here gets its default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        fields_nxt = fields;
        send_nxt   = 1'b0;
        go_nxt     = 1'b0;
        err_nxt    = cfg_err;
        red_nxt    = red_written;
        green_nxt  = green_written;

        case (state)
            ST_IDLE: begin
                // Go has priority: a send arriving with it is dropped
                // silently, without raising the error flag.
                if (p_go) begin
                    go_nxt    = 1'b1;
                    state_nxt = ST_RUN;
                end else if (p_send) begin
                    if (time_valid(sw_time)) begin
                        send_nxt   = 1'b1;
                        err_nxt    = 1'b0;
                        fields_nxt = '{sel: sw_sel, color: sw_color,
                                       start: sw_start, secs: sw_time};
                        // Selects beyond the last light are still forwarded
                        // but never mark a light as configured.
                        for (int n = 0; n < NUM_LIGHTS; n++) begin
                            if (int'(sw_sel) == n) begin
                                if (sw_color == COLOR_GREEN) begin
                                    green_nxt[n] = 1'b1;
                                end else begin
                                    red_nxt[n] = 1'b1;
                                end
                            end
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (p_go) begin
                    go_nxt    = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (p_send) begin
                    // Reconfiguring a running light is refused.
                    err_nxt = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            fields        <= '0;
            inst_send     <= 1'b0;
            inst_go       <= 1'b0;
            cfg_err       <= 1'b0;
            red_written   <= '0;
            green_written <= '0;
            cfg_mask      <= '0;
        end else begin
            state         <= state_nxt;
            fields        <= fields_nxt;
            inst_send     <= send_nxt;
            inst_go       <= go_nxt;
            cfg_err       <= err_nxt;
            red_written   <= red_nxt;
            green_written <= green_nxt;
            // Built from the already-registered written masks, so the mask
            // follows an accepted send by one cycle.
            cfg_mask      <= red_written & green_written;
        end
    end

    assign traffic_sel = fields.sel;
    assign color_sel   = fields.color;
    assign start_color = fields.start;
    assign input_time  = fields.secs;
    assign running     = (state == ST_RUN);

endmodule

// File: tb/tb_traffic_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_traffic_cmd_ctrl
// Directed bench for traffic_cmd_ctrl at DEBOUNCE_CYCLES = 4, where a button
// first sampled high at edge 0 yields a strobe visible after edge 7.
// Inputs change at the falling edge; outputs are sampled at the falling edge.
// -----------------------------------------------------------------------------
module tb_traffic_cmd_ctrl;

    localparam int DEB   = 4;
    localparam int NL    = 4;
    localparam int LAT   = DEB + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          btn_send = 1'b0;
    logic          btn_go = 1'b0;
    logic [1:0]    sw_sel = '0;
    logic          sw_color = 1'b0;
    logic          sw_start = 1'b0;
    logic [3:0]    sw_time = '0;
    logic          inst_send, inst_go;
    logic [1:0]    traffic_sel;
    logic          color_sel, start_color;
    logic [3:0]    input_time;
    logic          running, cfg_err;
    logic [NL-1:0] cfg_mask;

    int vectors     = 0;
    int miscompares = 0;

    traffic_cmd_ctrl #(.DEBOUNCE_CYCLES(DEB), .NUM_LIGHTS(NL)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_send    (btn_send),
        .btn_go      (btn_go),
        .sw_sel      (sw_sel),
        .sw_color    (sw_color),
        .sw_start    (sw_start),
        .sw_time     (sw_time),
        .inst_send   (inst_send),
        .inst_go     (inst_go),
        .traffic_sel (traffic_sel),
        .color_sel   (color_sel),
        .start_color (start_color),
        .input_time  (input_time),
        .running     (running),
        .cfg_err     (cfg_err),
        .cfg_mask    (cfg_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives the buttons high for 'hold' edges starting at the next rising
    // edge (edge 0), watches 'n' edges and checks strobe counts, the edge
    // index of the first expected strobe (-1 = none) and strobe exclusivity.
    task automatic press(input string tag, input logic s, input logic g,
                         input int hold, input int n,
                         input int exp_send, input int exp_go, input int exp_first);
        int send_cnt = 0, go_cnt = 0, both_cnt = 0, first = -1;
        btn_send = s;
        btn_go   = g;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == hold - 1) begin
                btn_send = 1'b0;
                btn_go   = 1'b0;
            end
            if (inst_send) begin
                if (exp_send > 0 && first < 0) first = k;
                send_cnt++;
            end
            if (inst_go) begin
                if (exp_send == 0 && first < 0) first = k;
                go_cnt++;
            end
            if (inst_send && inst_go) both_cnt++;
        end
        check({tag, ".send_cnt"}, send_cnt, exp_send);
        check({tag, ".go_cnt"},   go_cnt,   exp_go);
        check({tag, ".both"},     both_cnt, 0);
        if (exp_first >= 0) check({tag, ".latency"}, first, exp_first);
    endtask

    task automatic set_sw(input logic [1:0] sel, input logic color,
                          input logic start, input logic [3:0] t);
        sw_sel   = sel;
        sw_color = color;
        sw_start = start;
        sw_time  = t;
    endtask

    function automatic logic [15:0] all_outs();
        return {inst_send, inst_go, traffic_sel, color_sel, start_color,
                input_time, running, cfg_err, cfg_mask};
    endfunction

    initial begin
        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.all_outs", all_outs(), 16'h0);
        rst = 1'b1;

        // Valid send: sel 2, green, start 1, 7 s
        set_sw(2'd2, 1'b1, 1'b1, 4'd7);
        press("send1", 1'b1, 1'b0, 10, 20, 1, 0, LAT);
        check("send1.fields", {traffic_sel, color_sel, start_color, input_time},
              {2'd2, 1'b1, 1'b1, 4'd7});
        check("send1.cfg_err", cfg_err, 1'b0);

        // Fields hold while switches move; a 3-cycle glitch is ignored
        set_sw(2'd1, 1'b0, 1'b0, 4'd3);
        press("glitch", 1'b1, 1'b0, 3, 20, 0, 0, -1);
        check("glitch.input_time", input_time, 4'd7);
        check("glitch.traffic_sel", traffic_sel, 2'd2);

        // Zero time rejected
        set_sw(2'd1, 1'b0, 1'b0, 4'd0);
        press("zero_time", 1'b1, 1'b0, 10, 20, 0, 0, -1);
        check("zero_time.cfg_err", cfg_err, 1'b1);
        check("zero_time.input_time", input_time, 4'd7);

        // Valid red send to light 1 clears the error
        set_sw(2'd1, 1'b0, 1'b0, 4'd5);
        press("red_l1", 1'b1, 1'b0, 10, 20, 1, 0, LAT);
        check("red_l1.cfg_err", cfg_err, 1'b0);
        check("red_l1.input_time", input_time, 4'd5);
        check("red_l1.cfg_mask", cfg_mask, 4'b0000);

        // Green send to light 1 completes it
        set_sw(2'd1, 1'b1, 1'b0, 4'd6);
        press("green_l1", 1'b1, 1'b0, 10, 20, 1, 0, LAT);
        check("green_l1.cfg_mask", cfg_mask, 4'b0010);

        // Two red sends to light 3 never complete it
        set_sw(2'd3, 1'b0, 1'b1, 4'd8);
        press("red_l3a", 1'b1, 1'b0, 10, 20, 1, 0, LAT);
        press("red_l3b", 1'b1, 1'b0, 10, 20, 1, 0, LAT);
        check("red_l3.cfg_mask", cfg_mask, 4'b0010);

        // Go -> RUN
        press("go1", 1'b0, 1'b1, 10, 20, 0, 1, LAT);
        check("go1.running", running, 1'b1);

        // Send while running is rejected
        set_sw(2'd0, 1'b1, 1'b0, 4'd9);
        press("send_run", 1'b1, 1'b0, 10, 20, 0, 0, -1);
        check("send_run.cfg_err", cfg_err, 1'b1);
        check("send_run.input_time", input_time, 4'd8);
        check("send_run.traffic_sel", traffic_sel, 2'd3);
        check("send_run.running", running, 1'b1);

        // Go -> IDLE
        press("go2", 1'b0, 1'b1, 10, 20, 0, 1, LAT);
        check("go2.running", running, 1'b0);

        // Valid send clears the error before the simultaneous case
        set_sw(2'd0, 1'b1, 1'b0, 4'd2);
        press("send_clr", 1'b1, 1'b0, 10, 20, 1, 0, LAT);
        check("send_clr.cfg_err", cfg_err, 1'b0);

        // Both buttons rise together: go wins, send dropped, no error
        set_sw(2'd2, 1'b0, 1'b0, 4'd4);
        press("both", 1'b1, 1'b1, 10, 20, 0, 1, LAT);
        check("both.cfg_err", cfg_err, 1'b0);
        check("both.running", running, 1'b1);
        check("both.input_time", input_time, 4'd2);

        // Held for 100 cycles: one pulse only
        press("hold100", 1'b0, 1'b1, 100, 120, 0, 1, LAT);
        check("hold100.running", running, 1'b0);

        // Reset in RUN with send mid-debounce
        press("go3", 1'b0, 1'b1, 10, 20, 0, 1, LAT);
        check("go3.running", running, 1'b1);
        set_sw(2'd1, 1'b1, 1'b1, 4'd11);
        btn_send = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_run.all_outs", all_outs(), 16'h0);
        rst = 1'b1;

        // Button still held: full re-qualification from the first edge
        press("requal", 1'b1, 1'b0, 10, 20, 1, 0, LAT);
        check("requal.fields", {traffic_sel, color_sel, start_color, input_time},
              {2'd1, 1'b1, 1'b1, 4'd11});
        check("requal.cfg_mask", cfg_mask, 4'b0000);
        check("requal.running", running, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
